serial_receiver: RTL and testbench

- Downstream counterpart of the router's serial transmitter. Samples the single-wire S_Data stream on Clk_S, deframes one packet and checks it.
- Delivers the 55-bit word to the router input stage with a valid/taken handshake.
- Flags parity/framing errors and overruns.
- Same clock domain as the transmitter; no CDC inside this block.

---
 rtl/serial_pkg.sv | 18 +
 rtl/rx_shift_parity.sv | 43 ++++
 rtl/serial_receiver.sv | 134 +++++++++++++
 tb/tb_serial_receiver.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Frame constants and receiver state encodings shared by the serial link
// transmitter and receiver.
package serial_pkg;

    localparam int   DATA_W    = 55;
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;
    localparam logic IDLE_LVL  = 1'b0;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rx_shift_parity.sv
// Receive shift register: serial bits enter at the LSB so the first (MSB)
// bit ends up on top; a running XOR of everything shifted in rides along.
module rx_shift_parity #(
    parameter int DATA_W = 55
) (
    input  logic              Clk_S,
    input  logic              Rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data,
    output logic              par
);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;

    always_comb begin
        shift_d = shift_q;
        par_d   = par_q;
        if (clr) begin
            shift_d = '0;
            par_d   = 1'b0;
        end else if (shift_en) begin
            shift_d = {shift_q[DATA_W-2:0], bit_in};
            par_d   = par_q ^ bit_in;
        end
    end

    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    assign data = shift_q;
    assign par  = par_q;

endmodule

// File: rtl/serial_receiver.sv
// Single-wire serial deframer: start bit, MSB-first payload, optional even
// parity, stop bit; delivers the payload on a valid/taken handshake.
//
//   state     | meaning
//   ST_RST    | after reset, wait for the line to be seen low
//   ST_IDLE   | line idle, waiting for a start bit
//   ST_DATA   | shifting in payload bits
//   ST_PARITY | capturing the parity bit
//   ST_STOP   | sampling the stop bit and evaluating the frame
module serial_receiver #(
    parameter int DATA_W    = 55,
    parameter int PARITY_EN = 1,
    parameter int CNT_W     = 6
) (
    input  logic              Clk_S,
    input  logic              Rst_n,
    input  logic              S_Data,
    input  logic              RX_Data_Taken,
    output logic [DATA_W-1:0] RX_Data,
    output logic              RX_Data_Valid,
    output logic              RX_Error,
    output logic              RX_Overrun,
    output logic              RX_Busy
);
    import serial_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_bit_q, par_bit_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              ovr_q, ovr_d;
    logic              busy_q, busy_d;

    logic              sr_clr, sr_shift, sr_par;
    logic [DATA_W-1:0] sr_data;
    logic              frame_done, frame_bad;

    assign sr_clr   = (state_q == ST_IDLE) && (S_Data == START_BIT);
    assign sr_shift = (state_q == ST_DATA);

    rx_shift_parity #(.DATA_W(DATA_W)) u_shift (
        .Clk_S    (Clk_S),
        .Rst_n    (Rst_n),
        .clr      (sr_clr),
        .shift_en (sr_shift),
        .bit_in   (S_Data),
        .data     (sr_data),
        .par      (sr_par)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        par_bit_d  = par_bit_q;
        rx_data_d  = rx_data_q;
        valid_d    = valid_q;
        err_d      = 1'b0;
        ovr_d      = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            ST_RST: begin
                if (S_Data == IDLE_LVL) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (S_Data == START_BIT) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                par_bit_d = S_Data;
                state_d   = ST_STOP;
            end
            ST_STOP: begin
                frame_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_RST;
        endcase

        frame_bad = (S_Data != STOP_BIT) || ((PARITY_EN != 0) && (sr_par ^ par_bit_q));

        // A good frame wins over a same-cycle take: the take consumes the old word.
        if (frame_done && frame_bad) err_d = 1'b1;
        if (frame_done && !frame_bad && (!valid_q || RX_Data_Taken)) begin
            rx_data_d = sr_data;
            valid_d   = 1'b1;
        end else if (frame_done && !frame_bad) begin
            ovr_d = 1'b1;
        end else if (RX_Data_Taken) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d == ST_DATA) || (state_d == ST_PARITY) || (state_d == ST_STOP);
    end

    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_RST;
            cnt_q     <= '0;
            par_bit_q <= 1'b0;
            rx_data_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            par_bit_q <= par_bit_d;
            rx_data_q <= rx_data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign RX_Data       = rx_data_q;
    assign RX_Data_Valid = valid_q;
    assign RX_Error      = err_q;
    assign RX_Overrun    = ovr_q;
    assign RX_Busy       = busy_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: a frame-level reference model collects whole
// frames and judges them arithmetically; outputs are compared every cycle.
module tb_serial_receiver;

    localparam int DATA_W    = 55;
    localparam int PARITY_EN = 1;
    localparam int FR_LEN    = DATA_W + PARITY_EN + 1;

    localparam logic [DATA_W-1:0] P_A  = 55'h2A_AAAA_AAAA_AAAA;
    localparam logic [DATA_W-1:0] P_1  = 55'h1;
    localparam logic [DATA_W-1:0] P_F  = 55'h7F_FFFF_FFFF_FFFF;
    localparam logic [DATA_W-1:0] P_5  = 55'h12_3456_789A_BCDE;
    localparam logic [DATA_W-1:0] P_B  = 55'h55_0F0F_00FF_1234;
    localparam logic [DATA_W-1:0] P_C  = 55'h3C_DEAD_BEEF_0001;
    localparam logic [DATA_W-1:0] P_D  = 55'h0A_5A5A_C3C3_7E7E;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_data;
    logic              taken;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid, rx_err, rx_ovr, rx_busy;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    bit rand_take = 1'b0;
    int pcnt = 0;
    int start_edge = 0;
    int rise_edge = -1;
    int err_cnt = 0;
    int ovr_cnt = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    serial_receiver #(.DATA_W(DATA_W), .PARITY_EN(PARITY_EN), .CNT_W(6)) dut (
        .Clk_S         (clk),
        .Rst_n         (rst_n),
        .S_Data        (s_data),
        .RX_Data_Taken (taken),
        .RX_Data       (rx_data),
        .RX_Data_Valid (rx_valid),
        .RX_Error      (rx_err),
        .RX_Overrun    (rx_ovr),
        .RX_Busy       (rx_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: 0 = waiting for low line, 1 = idle, 2 = collecting a frame
    int                m_state;
    bit                m_bits[$];
    logic [DATA_W-1:0] exp_data;
    bit                exp_valid, exp_err, exp_ovr, exp_busy;
    bit                m_done, m_bad;
    int                m_ones;
    logic [DATA_W-1:0] m_pay;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_bits.delete();
            exp_data = '0;
            exp_valid = 0; exp_err = 0; exp_ovr = 0; exp_busy = 0;
        end else begin
            m_done = 0;
            exp_err = 0;
            exp_ovr = 0;
            case (m_state)
                0: if (s_data == 1'b0) m_state = 1;
                1: if (s_data == 1'b1) begin m_state = 2; m_bits.delete(); end
                default: begin
                    m_bits.push_back(s_data);
                    if (m_bits.size() == FR_LEN) begin m_done = 1; m_state = 1; end
                end
            endcase
            if (m_done) begin
                m_ones = 0;
                for (int i = 0; i < DATA_W; i++) begin
                    m_pay[DATA_W-1-i] = m_bits[i];
                    m_ones += int'(m_bits[i]);
                end
                if (PARITY_EN != 0) m_ones += int'(m_bits[DATA_W]);
                m_bad = (m_bits[FR_LEN-1] != 1'b0) || (m_ones % 2 != 0);
                if (m_bad) begin
                    exp_err = 1;
                    if (taken) exp_valid = 0;
                end else if (!exp_valid || taken) begin
                    exp_data = m_pay;
                    exp_valid = 1;
                end else begin
                    exp_ovr = 1;
                end
            end else if (taken && exp_valid) begin
                exp_valid = 0;
            end
            exp_busy = (m_state == 2);
        end
    end

    always @(posedge clk) pcnt++;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rx_data",  64'(rx_data),  64'(exp_data));
            chk("rx_valid", 64'(rx_valid), 64'(exp_valid));
            chk("rx_error", 64'(rx_err),   64'(exp_err));
            chk("rx_ovr",   64'(rx_ovr),   64'(exp_ovr));
            chk("rx_busy",  64'(rx_busy),  64'(exp_busy));
        end
        if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_edge = pcnt;
        prev_valid = rx_valid;
        if (rx_err === 1'b1) err_cnt++;
        if (rx_ovr === 1'b1) ovr_cnt++;
    end

    task automatic drive(input logic b, input logic tk);
        @(negedge clk);
        #1;
        s_data = b;
        taken = rand_take ? ($urandom_range(0, 2) == 0) : tk;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] p, input bit flip_par,
                              input bit bad_stop, input bit take_stop);
        drive(1'b1, 1'b0);
        start_edge = pcnt + 1;
        for (int i = DATA_W - 1; i >= 0; i--) drive(p[i], 1'b0);
        if (PARITY_EN != 0) drive((^p) ^ flip_par, 1'b0);
        drive(bad_stop, take_stop);
    endtask

    task automatic do_reset(input logic line);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        s_data = line;
        taken = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        err_cnt = 0;
        ovr_cnt = 0;
        rise_edge = -1;
    endtask

    logic [DATA_W-1:0] rp;
    int kind;

    initial begin
        rst_n = 1'b0;
        s_data = 1'b0;
        taken = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_valid", 64'(rx_valid), 64'd0);
        chk("reset_data", 64'(rx_data), 64'd0);
        do_reset(1'b0);

        // good frame, latency from start edge to valid
        idle(3);
        send_frame(P_A, 0, 0, 0);
        idle(2);
        chk("latency_A", 64'(rise_edge - start_edge), 64'd57);
        chk("data_A", 64'(rx_data), 64'(P_A));
        chk("model_data_A", 64'(exp_data), 64'h2A_AAAA_AAAA_AAAA);
        chk("err_A", 64'(err_cnt), 64'd0);

        // parity error then stop-bit error
        do_reset(1'b0);
        idle(2);
        send_frame(P_A, 1, 0, 0);
        idle(2);
        chk("par_err_cnt", 64'(err_cnt), 64'd1);
        chk("par_err_valid", 64'(rx_valid), 64'd0);
        chk("par_err_data", 64'(rx_data), 64'd0);
        send_frame(P_A, 0, 1, 0);
        idle(2);
        chk("stop_err_cnt", 64'(err_cnt), 64'd2);
        chk("stop_err_valid", 64'(rx_valid), 64'd0);

        // back-to-back, no take: overrun
        do_reset(1'b0);
        idle(2);
        send_frame(P_1, 0, 0, 0);
        send_frame(P_F, 0, 0, 0);
        idle(2);
        chk("ovr_cnt", 64'(ovr_cnt), 64'd1);
        chk("ovr_data", 64'(rx_data), 64'h1);
        chk("model_ovr_data", 64'(exp_data), 64'h1);
        chk("ovr_valid", 64'(rx_valid), 64'd1);

        // back-to-back, take on second stop edge: replacement
        do_reset(1'b0);
        idle(2);
        send_frame(P_1, 0, 0, 0);
        send_frame(P_F, 0, 0, 1);
        idle(2);
        chk("take_ovr_cnt", 64'(ovr_cnt), 64'd0);
        chk("take_data", 64'(rx_data), 64'h7F_FFFF_FFFF_FFFF);
        chk("take_valid", 64'(rx_valid), 64'd1);

        // line stuck high through reset release
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0);
        chk("stuck_busy", 64'(rx_busy), 64'd0);
        chk("stuck_valid", 64'(rx_valid), 64'd0);
        idle(1);
        send_frame(P_5, 0, 0, 0);
        idle(2);
        chk("after_stuck_data", 64'(rx_data), 64'(P_5));
        chk("after_stuck_valid", 64'(rx_valid), 64'd1);

        // reset in the middle of data bit 30
        do_reset(1'b0);
        idle(1);
        send_frame(P_B, 0, 0, 0);
        idle(1);
        drive(1'b1, 1'b0);
        for (int i = DATA_W - 1; i >= DATA_W - 31; i--) drive(P_C[i], 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(rx_valid), 64'd0);
        chk("midrst_data", 64'(rx_data), 64'd0);
        chk("midrst_busy", 64'(rx_busy), 64'd0);
        s_data = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        err_cnt = 0;
        idle(2);
        send_frame(P_D, 0, 0, 0);
        idle(2);
        chk("midrst_new_data", 64'(rx_data), 64'(P_D));
        chk("midrst_new_err", 64'(err_cnt), 64'd0);

        // randomized frames with random corruption, gaps and takes
        do_reset(1'b0);
        idle(1);
        rand_take = 1'b1;
        for (int f = 0; f < 40; f++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) drive(1'b0, 1'b0);
            rp = DATA_W'({$urandom(), $urandom()});
            kind = int'($urandom_range(0, 5));
            send_frame(rp, kind == 0, kind == 1, 1'b0);
        end
        rand_take = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
